// File: rtl/echo_delay.sv
// Echo/delay effect stage: a circular sample buffer with feedback, mixing the delayed sample onto the dry input.
// Each accepted sample runs through a fixed four-cycle sequence: IDLE, READ, CALC, WRITE.
module echo_delay #(
  parameter int WIDTH  = 12,
  parameter int ADDR_W = 12,
  parameter int GAIN_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  input  logic [WIDTH-1:0]  x,
  input  logic [ADDR_W-1:0] delay_len,
  input  logic [GAIN_W-1:0] fb_gain,
  input  logic [GAIN_W-1:0] mix,
  input  logic              bypass,
  output logic [WIDTH-1:0]  y,
  output logic              done,
  output logic [1:0]        dbg_state
);
  // Handshake: ready is a one-cycle strobe that is accepted only in IDLE; a ready seen in
  // any other state is dropped. done pulses for one cycle, three edges after the accepting edge,
  // and y holds its value until the next done.
  localparam int PW = WIDTH + GAIN_W + 1;
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, READ, CALC, WRITE} state_t;
  state_t state, next_state;

  logic              latch_en, calc_en, write_en;
  logic [WIDTH-1:0]  x_r, ram_q, echo;
  logic [GAIN_W-1:0] mix_r, fb_r;
  logic              byp_r;
  logic [ADDR_W-1:0] eff_len, eff_r, rd_addr, wr_ptr, fill;
  logic [WIDTH:0]    wet_r, fbk_r;
  logic signed [PW-1:0] echo_x, mix_x, fb_x, wet_p, fbk_p;
  logic [WIDTH+1:0]  sum_y, sum_f;
  logic [WIDTH-1:0]  ram [2**ADDR_W];

  function automatic logic [WIDTH-1:0] sat(input logic [WIDTH+1:0] s);
    if (s[WIDTH+1:WIDTH-1] == 3'b000 || s[WIDTH+1:WIDTH-1] == 3'b111)
      return s[WIDTH-1:0];
    else if (s[WIDTH+1])
      return {1'b1, {(WIDTH-1){1'b0}}};
    else
      return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (ready) next_state = READ;
      READ:    next_state = CALC;
      CALC:    next_state = WRITE;
      WRITE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    latch_en  = (state == IDLE) && ready;
    calc_en   = (state == CALC);
    write_en  = (state == WRITE);
    dbg_state = state;
  end

  assign eff_len = (delay_len == '0) ? ONE : delay_len;

  // Fill gates the read so stale RAM left over from before a reset never leaks into the echo.
  always_comb begin
    echo   = (fill >= eff_r) ? ram_q : '0;
    echo_x = {{(GAIN_W+1){echo[WIDTH-1]}}, echo};
    mix_x  = {{(WIDTH+1){1'b0}}, mix_r};
    fb_x   = {{(WIDTH+1){1'b0}}, fb_r};
    wet_p  = echo_x * mix_x;
    fbk_p  = echo_x * fb_x;
    sum_y  = {{2{x_r[WIDTH-1]}}, x_r} + {wet_r[WIDTH], wet_r};
    sum_f  = {{2{x_r[WIDTH-1]}}, x_r} + {fbk_r[WIDTH], fbk_r};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_r     <= '0;
      mix_r   <= '0;
      fb_r    <= '0;
      byp_r   <= 1'b0;
      eff_r   <= ONE;
      rd_addr <= '0;
      wr_ptr  <= '0;
      fill    <= '0;
      wet_r   <= '0;
      fbk_r   <= '0;
      y       <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (latch_en) begin
        x_r     <= x;
        mix_r   <= mix;
        fb_r    <= fb_gain;
        byp_r   <= bypass;
        eff_r   <= eff_len;
        rd_addr <= wr_ptr - eff_len;
      end
      if (calc_en) begin
        // Taking the upper bits of the product is an arithmetic shift right by GAIN_W.
        wet_r <= wet_p[PW-1:GAIN_W];
        fbk_r <= fbk_p[PW-1:GAIN_W];
      end
      if (write_en) begin
        y      <= byp_r ? x_r : sat(sum_y);
        done   <= 1'b1;
        wr_ptr <= wr_ptr + ONE;
        if (fill != {ADDR_W{1'b1}}) fill <= fill + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (write_en && !reset) ram[wr_ptr] <= sat(sum_f);
    ram_q <= ram[rd_addr];
  end
endmodule
